// File: rtl/hlsm_job_driver_if.sv
// rtl/hlsm_job_driver_if.sv - operand stream, HLSM Start/Done and result stream bundle
interface hlsm_job_driver_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic signed [DATA_W-1:0] in_c;
  logic                     hs_start;
  logic                     hs_done;
  logic signed [DATA_W-1:0] hs_a;
  logic signed [DATA_W-1:0] hs_b;
  logic signed [DATA_W-1:0] hs_c;
  logic signed [DATA_W-1:0] hs_z;
  logic signed [DATA_W-1:0] hs_x;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_z;
  logic signed [DATA_W-1:0] out_x;

  modport master (
    input  in_valid, in_a, in_b, in_c, hs_done, hs_z, hs_x, out_ready,
    output in_ready, hs_start, hs_a, hs_b, hs_c, out_valid, out_z, out_x
  );

  modport slave (
    output in_valid, in_a, in_b, in_c, hs_done, hs_z, hs_x, out_ready,
    input  in_ready, hs_start, hs_a, hs_b, hs_c, out_valid, out_z, out_x
  );
endinterface

// File: rtl/hlsm_job_driver.sv
// rtl/hlsm_job_driver.sv - HLSM Start/Done job initiator with timeout watchdog
// Optional HLSM_DRV_LAT_EN adds last_lat (start-to-done latency of the last good job).
module hlsm_job_driver #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  hlsm_job_driver_if.master  bus,
  output logic               busy,
  output logic               timeout_err,
`ifdef HLSM_DRV_LAT_EN
  output logic [15:0]        last_lat,
`endif
  output logic [CNT_W-1:0]   job_count
);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]               state;
  logic [WD_W-1:0]          wd;
  logic                     hs_start_q;
  logic signed [DATA_W-1:0] hs_a_q, hs_b_q, hs_c_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_z_q, out_x_q;
  logic                     in_ready_c;
  logic                     accept;
  logic                     wd_expired;

  // A triple is only taken when the result slot will be free by the time Done can arrive.
  assign in_ready_c = (state == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

  assign bus.in_ready  = in_ready_c;
  assign bus.hs_start  = hs_start_q;
  assign bus.hs_a      = hs_a_q;
  assign bus.hs_b      = hs_b_q;
  assign bus.hs_c      = hs_c_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_x     = out_x_q;
  assign busy          = (state != S_IDLE);

`ifdef HLSM_DRV_LAT_EN
  logic [15:0] lat_cnt;
  logic [15:0] lat_next;
  assign lat_next = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      wd          <= '0;
      hs_start_q  <= 1'b0;
      hs_a_q      <= '0;
      hs_b_q      <= '0;
      hs_c_q      <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_x_q     <= '0;
      timeout_err <= 1'b0;
      job_count   <= '0;
`ifdef HLSM_DRV_LAT_EN
      lat_cnt     <= 16'd0;
      last_lat    <= 16'd0;
`endif
    end else begin
      hs_start_q <= 1'b0;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            hs_a_q     <= bus.in_a;
            hs_b_q     <= bus.in_b;
            hs_c_q     <= bus.in_c;
            wd         <= '0;
            hs_start_q <= 1'b1;
            state      <= S_LAUNCH;
`ifdef HLSM_DRV_LAT_EN
            lat_cnt    <= 16'd1;
`endif
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over an expiring watchdog in the same cycle.
          if (bus.hs_done) begin
            out_z_q     <= bus.hs_z;
            out_x_q     <= bus.hs_x;
            out_valid_q <= 1'b1;
            job_count   <= job_count + 1'b1;
            state       <= S_IDLE;
`ifdef HLSM_DRV_LAT_EN
            last_lat    <= lat_next;
`endif
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
`ifdef HLSM_DRV_LAT_EN
            lat_cnt <= lat_next;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
